// File: rtl/dca_matrix_lsu_load_streamer_pkg.sv
// Shared definitions for the DCA matrix load streamer: FSM state encoding
// and width helpers derived from the matrix size / tensor format codes.
package dca_matrix_lsu_load_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } lsu_state_e;

  // Element width in bits for a tensor format code.
  function automatic int elem_bits(input int tcode);
    case (tcode)
      32'sd0:  return 32'sd8;
      32'sd1:  return 32'sd16;
      32'sd2:  return 32'sd32;
      default: return 32'sd8;
    endcase
  endfunction

  // Width of a row count 0..MATRIX_SIZE.
  function automatic int num_row_bits(input int msize);
    return $clog2(msize) + 32'sd1;
  endfunction

  // Width of one tensor row (MATRIX_SIZE elements).
  function automatic int tensor_row_bits(input int msize, input int tcode);
    return msize * elem_bits(tcode);
  endfunction

endpackage

// File: rtl/dca_matrix_lsu_load_streamer_chk.sv
// Protocol checker: memory must only answer when a read is pending.
module dca_matrix_lsu_load_streamer_chk (
  input logic i_clk,
  input logic i_rstnn,
  input logic i_enable,
  input logic i_mem_rvalid,
  input logic i_pending
);

  a_rsp_has_request: assert property (
    @(posedge i_clk) disable iff (!i_rstnn)
    (i_enable && i_mem_rvalid) |-> i_pending
  ) else $error("memory response arrived with no read outstanding; data dropped");

endmodule

// File: rtl/dca_matrix_lsu_load_streamer_fifo.sv
// In-order row buffer. Output is the head entry (zero while empty); a
// push into a full buffer is only taken together with a pop.
module dca_matrix_lsu_load_streamer_fifo
  import dca_matrix_lsu_load_streamer_pkg::*;
#(
  parameter int BW_DATA = 64,
  parameter int DEPTH   = 4,
  localparam int BW_CNT = $clog2(DEPTH) + 1
)(
  input  logic               clk,
  input  logic               rstnn,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [BW_DATA-1:0] i_data,
  output logic [BW_DATA-1:0] o_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [BW_CNT-1:0]  o_count
);

  localparam int BW_PTR = $clog2(DEPTH);

  logic [BW_DATA-1:0] r_mem [DEPTH];
  logic [BW_PTR:0]    r_wr_ptr;
  logic [BW_PTR:0]    r_rd_ptr;
  logic [BW_PTR:0]    w_count;
  logic               w_empty;
  logic               w_full;
  logic               w_do_pop;
  logic               w_do_push;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_count == (BW_PTR+1)'(0));
  assign w_full    = (w_count == (BW_PTR+1)'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = BW_CNT'(w_count);
  assign o_data  = w_empty ? {BW_DATA{1'b0}} : r_mem[r_rd_ptr[BW_PTR-1:0]];

  // Row storage write; content of empty slots is never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[BW_PTR-1:0]] <= i_data;
    end
  end

  // Read/write pointers with flush back to empty.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (BW_PTR+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (BW_PTR+1)'(1);
    end
  end

endmodule

// File: rtl/dca_matrix_lsu_load_streamer.sv
// Memory-side responder for one DCA matrix load port: one read per row,
// in-order responses buffered, rows streamed on the load_tensor_row port.
module dca_matrix_lsu_load_streamer
  import dca_matrix_lsu_load_streamer_pkg::*;
#(
  parameter int MATRIX_SIZE_PARA = 8,
  parameter int TENSOR_PARA      = 0,
  parameter int BW_ADDR          = 32,
  parameter int BUF_DEPTH        = 4,
  localparam int BW_NUM_ROW      = num_row_bits(MATRIX_SIZE_PARA),
  localparam int BW_TENSOR_ROW   = tensor_row_bits(MATRIX_SIZE_PARA, TENSOR_PARA)
)(
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     enable,
  output logic                     busy,
  output logic                     inst_wready,
  input  logic                     inst_wvalid,
  input  logic [BW_ADDR-1:0]       inst_addr,
  input  logic [BW_ADDR-1:0]       inst_stride,
  input  logic [BW_NUM_ROW-1:0]    inst_num_row,
  output logic                     mem_rrequest,
  input  logic                     mem_rready,
  output logic [BW_ADDR-1:0]       mem_raddr,
  input  logic                     mem_rvalid,
  input  logic [BW_TENSOR_ROW-1:0] mem_rdata,
  input  logic                     load_tensor_row_wready,
  output logic                     load_tensor_row_wvalid,
  output logic                     load_tensor_row_wlast,
  output logic [BW_TENSOR_ROW-1:0] load_tensor_row_wdata,
  output logic                     done
);

  localparam int BW_CNT = $clog2(BUF_DEPTH) + 1;

  lsu_state_e              r_state;
  lsu_state_e              w_state_nxt;
  logic [BW_ADDR-1:0]      r_addr;
  logic [BW_ADDR-1:0]      r_stride;
  logic [BW_NUM_ROW-1:0]   r_num_row;
  logic [BW_NUM_ROW-1:0]   r_issued;
  logic [BW_NUM_ROW-1:0]   r_popped;
  logic [BW_CNT-1:0]       r_outstanding;
  logic [BW_CNT-1:0]       r_discard;
  logic                    r_done;
  logic                    w_done_nxt;

  logic [BW_TENSOR_ROW-1:0] w_fifo_head;
  logic                     w_fifo_empty;
  logic                     w_fifo_full;
  logic [BW_CNT-1:0]        w_fifo_count;

  logic                w_inst_wready;
  logic                w_cmd_acc;
  logic                w_credit_ok;
  logic                w_rreq;
  logic                w_req_acc;
  logic                w_rsp;
  logic                w_pending;
  logic                w_rsp_discard;
  logic                w_rsp_push;
  logic                w_wvalid;
  logic                w_pop;
  logic                w_last_head;
  logic [BW_CNT:0]     w_pend_total;
  logic [BW_CNT-1:0]   w_discard_clr;

  // Credit counts in-flight reads plus buffered rows so responses never overflow.
  assign w_credit_ok   = (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (BW_CNT+1)'(BUF_DEPTH));
  assign w_inst_wready = enable && (r_state == ST_IDLE) && (r_discard == BW_CNT'(0));
  assign w_cmd_acc     = inst_wvalid && w_inst_wready;
  assign w_rreq        = enable && (r_state == ST_ISSUE) && (r_issued < r_num_row) && w_credit_ok;
  assign w_req_acc     = w_rreq && mem_rready;
  assign w_rsp         = enable && mem_rvalid;
  assign w_pending     = (r_discard != BW_CNT'(0)) || (r_outstanding != BW_CNT'(0));
  // Responses to reads orphaned by clear are older, so they are consumed first.
  assign w_rsp_discard = w_rsp && (r_discard != BW_CNT'(0));
  assign w_rsp_push    = w_rsp && (r_discard == BW_CNT'(0)) && (r_outstanding != BW_CNT'(0));
  assign w_wvalid      = enable && !w_fifo_empty;
  assign w_pop         = w_wvalid && load_tensor_row_wready;
  assign w_last_head   = (r_popped == (r_num_row - BW_NUM_ROW'(1)));

  // Reads still owed by memory after a clear, including one accepted in the clear cycle.
  assign w_pend_total  = {1'b0, r_discard} + {1'b0, r_outstanding} + (BW_CNT+1)'(w_req_acc);
  assign w_discard_clr = BW_CNT'(w_pend_total - (BW_CNT+1)'(w_rsp && w_pending));

  assign busy                   = (r_state != ST_IDLE) || w_pending || !w_fifo_empty;
  assign inst_wready            = w_inst_wready;
  assign mem_rrequest           = w_rreq;
  assign mem_raddr              = r_addr;
  assign load_tensor_row_wvalid = w_wvalid;
  assign load_tensor_row_wlast  = w_wvalid && w_last_head;
  assign load_tensor_row_wdata  = w_fifo_head;
  assign done                   = r_done;

  dca_matrix_lsu_load_streamer_fifo #(
    .BW_DATA (BW_TENSOR_ROW),
    .DEPTH   (BUF_DEPTH)
  ) u_row_buf (
    .clk     (clk),
    .rstnn   (rstnn),
    .i_flush (clear),
    .i_push  (w_rsp_push),
    .i_pop   (w_pop),
    .i_data  (mem_rdata),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  dca_matrix_lsu_load_streamer_chk u_chk (
    .i_clk        (clk),
    .i_rstnn      (rstnn),
    .i_enable     (enable),
    .i_mem_rvalid (mem_rvalid),
    .i_pending    (w_pending)
  );

  // Next-state and done-pulse decode for the command FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc && (inst_num_row != BW_NUM_ROW'(0))) begin
          w_state_nxt = ST_ISSUE;
        end else if (w_cmd_acc) begin
          w_done_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_req_acc && (r_issued == (r_num_row - BW_NUM_ROW'(1)))) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (w_pop && w_last_head) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and done pulse; clear wins over enable and suppresses done.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else if (enable) begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end else begin
      r_done  <= 1'b0;
    end
  end

  // Command registers, read address walk and row issue/pop counters.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_addr    <= '0;
      r_stride  <= '0;
      r_num_row <= '0;
      r_issued  <= '0;
      r_popped  <= '0;
    end else if (clear) begin
      r_issued  <= '0;
      r_popped  <= '0;
    end else if (enable) begin
      if (w_cmd_acc) begin
        r_addr    <= inst_addr;
        r_stride  <= inst_stride;
        r_num_row <= inst_num_row;
        r_issued  <= '0;
        r_popped  <= '0;
      end else begin
        if (w_req_acc) begin
          r_addr   <= r_addr + r_stride;
          r_issued <= r_issued + BW_NUM_ROW'(1);
        end
        if (w_pop) begin
          r_popped <= r_popped + BW_NUM_ROW'(1);
        end
      end
    end
  end

  // Outstanding-read and discard counters.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (clear) begin
      r_outstanding <= '0;
      r_discard     <= w_discard_clr;
    end else if (enable) begin
      r_outstanding <= r_outstanding + BW_CNT'(w_req_acc) - BW_CNT'(w_rsp_push);
      if (w_rsp_discard) begin
        r_discard <= r_discard - BW_CNT'(1);
      end
    end
  end

endmodule
